line_buffer_3row: RTL and testbench

//  Row-tap generator feeding the 3x3 window (erosion/dilation) stages: takes one raster pixel stream and

---
 rtl/img_pkg.sv | 27 ++
 rtl/line_buffer_3row_if.sv | 35 +++
 rtl/line_buffer_3row_line_ram.sv | 58 +++++
 rtl/line_buffer_3row.sv | 174 +++++++++++++++++
 tb/tb_line_buffer_3row.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// ----------------------------------------------------------------------------
// img_pkg
// Shared definitions for the image-processing pipeline: default pixel width
// and frame geometry, the raster counter width, and the per-pixel control
// record that travels down the row-tap pipeline alongside the pixel data.
// ----------------------------------------------------------------------------
package img_pkg;

  localparam int WIDTH_DEF      = 24;   // RGB888
  localparam int PIC_WIDTH_DEF  = 320;
  localparam int PIC_HEIGHT_DEF = 240;
  localparam int CNT_W          = 9;    // covers geometry up to 511

  typedef logic [CNT_W-1:0] cnt_t;

  // Control that accompanies one pixel through the pipeline. The flags are
  // resolved when the pixel is accepted, so a later sof or counter wrap
  // cannot change how an in-flight pixel is reported.
  typedef struct packed {
    logic vld;  // a pixel occupies this stage
    logic tap;  // row >= 2: all three window rows hold real data
    logic eol;  // last column of its row
    logic eof;  // last pixel of the frame
    cnt_t col;  // column, used as the line-memory address
  } stage_t;

endpackage

// File: rtl/line_buffer_3row_if.sv
// ----------------------------------------------------------------------------
// line_buffer_3row_if
// Pixel-stream in / row-tap out bundle for the 3-row line buffer.
//   sof, valid_in, din                      : raster pixel stream
//   valid_out, dout1..3, eol_out, eof_out   : column-aligned row taps
// master: the side that produces pixels and consumes taps.
// slave : the line buffer itself.
// ----------------------------------------------------------------------------
interface line_buffer_3row_if
  import img_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             sof;
  logic             valid_in;
  logic [WIDTH-1:0] din;
  logic             valid_out;
  logic [WIDTH-1:0] dout1;
  logic [WIDTH-1:0] dout2;
  logic [WIDTH-1:0] dout3;
  logic             eol_out;
  logic             eof_out;

  modport master (
    output sof, valid_in, din,
    input  valid_out, dout1, dout2, dout3, eol_out, eof_out
  );

  modport slave (
    input  sof, valid_in, din,
    output valid_out, dout1, dout2, dout3, eol_out, eof_out
  );

endinterface

// File: rtl/line_buffer_3row_line_ram.sv
// ----------------------------------------------------------------------------
// line_ram
// Simple dual-port synchronous RAM holding one image row.
//   clk          : clock
//   re, raddr    : read enable / address; data appears on rdata after the edge
//   rdata        : registered read data, holds while re is low
//   we, waddr,
//   wdata        : write port
// Depth DEPTH x WIDTH. Addresses arrive at raster-counter width and are
// narrowed to the memory's own address width here.
// ----------------------------------------------------------------------------
module line_ram
  import img_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = PIC_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             re,
  input  cnt_t             raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic             we,
  input  cnt_t             waddr,
  input  logic [WIDTH-1:0] wdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic [AW-1:0]    ra;
  logic [AW-1:0]    wa;

  assign ra = AW'(raddr);
  assign wa = AW'(waddr);

  // NOTE: every variable written in always_comb gets a value on every path
  // (here the hold value first); a path that leaves it unassigned infers a latch.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[ra];
    end
  end

  // NOTE: the storage array has no reset. Clearing it would need a sweep
  // state machine or force it out of block RAM; the top gates stale rows instead.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wa] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_buffer_3row.sv
// ----------------------------------------------------------------------------
// line_buffer_3row
// Row-tap generator for the 3x3 window stages. Takes one raster pixel stream
// and, per pixel, emits the pixels of the same column from rows y-2, y-1, y.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : line_buffer_3row_if.slave
//            in : sof, valid_in, din
//            out: valid_out, dout1 (row y-2), dout2 (row y-1), dout3 (row y),
//                 eol_out, eof_out
// Pipeline (advances every cycle, bubbles propagate):
//   edge N   : pixel accepted into stage 1
//   edge N+1 : RAM_A/RAM_B read at its column, pixel moves to stage 2
//   edge N+2 : taps registered on the outputs; RAM_A[col] <= pixel,
//              RAM_B[col] <= old RAM_A[col] (the row cascade)
// A pixel's read (N+1) and its write (N+2) bracket the neighbouring
// pixel's accesses at a different column, so no read/write collision exists
// for PIC_WIDTH >= 3.
// ----------------------------------------------------------------------------
module line_buffer_3row
  import img_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PIC_WIDTH  = PIC_WIDTH_DEF,
  parameter int PIC_HEIGHT = PIC_HEIGHT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  line_buffer_3row_if.slave bus
);

  localparam cnt_t COL_LAST = cnt_t'(PIC_WIDTH - 1);
  localparam cnt_t ROW_LAST = cnt_t'(PIC_HEIGHT - 1);
  localparam cnt_t ROW_TAP0 = cnt_t'(2);

  // Raster position of the next pixel.
  cnt_t col_q, col_d;
  cnt_t row_q, row_d;
  // Position of the pixel on the bus this cycle (sof overrides the counters).
  cnt_t col_cur, row_cur;

  stage_t           s1_q, s1_d;
  stage_t           s2_q, s2_d;
  logic [WIDTH-1:0] din_d1_q, din_d1_d;
  logic [WIDTH-1:0] din_d2_q, din_d2_d;

  logic             valid_out_q, valid_out_d;
  logic             eol_out_q, eol_out_d;
  logic             eof_out_q, eof_out_d;
  logic [WIDTH-1:0] dout1_q, dout1_d;
  logic [WIDTH-1:0] dout2_q, dout2_d;
  logic [WIDTH-1:0] dout3_q, dout3_d;

  logic [WIDTH-1:0] ram_a_rdata;  // row y-1 at this column
  logic [WIDTH-1:0] ram_b_rdata;  // row y-2 at this column
  logic             fire;

  // --------------------------------------------------------------------------
  // Raster counters
  // --------------------------------------------------------------------------
  always_comb begin
    col_cur = bus.sof ? '0 : col_q;
    row_cur = bus.sof ? '0 : row_q;
    col_d   = col_cur;
    row_d   = row_cur;
    if (bus.valid_in) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1 capture and stage 2 advance
  // --------------------------------------------------------------------------
  always_comb begin
    s1_d     = '0;
    s1_d.vld = bus.valid_in;
    s1_d.tap = (row_cur >= ROW_TAP0);
    s1_d.eol = (col_cur == COL_LAST);
    s1_d.eof = (col_cur == COL_LAST) && (row_cur == ROW_LAST);
    s1_d.col = col_cur;
    din_d1_d = bus.valid_in ? bus.din : din_d1_q;

    s2_d     = s1_q;
    din_d2_d = din_d1_q;
  end

  // --------------------------------------------------------------------------
  // Line memories: RAM_A holds row y-1, RAM_B holds row y-2.
  // --------------------------------------------------------------------------
  line_ram #(
    .WIDTH (WIDTH),
    .DEPTH (PIC_WIDTH)
  ) u_ram_a (
    .clk   (clk),
    .re    (s1_q.vld),
    .raddr (s1_q.col),
    .rdata (ram_a_rdata),
    .we    (s2_q.vld),
    .waddr (s2_q.col),
    .wdata (din_d2_q)
  );

  line_ram #(
    .WIDTH (WIDTH),
    .DEPTH (PIC_WIDTH)
  ) u_ram_b (
    .clk   (clk),
    .re    (s1_q.vld),
    .raddr (s1_q.col),
    .rdata (ram_b_rdata),
    .we    (s2_q.vld),
    .waddr (s2_q.col),
    .wdata (ram_a_rdata)
  );

  // --------------------------------------------------------------------------
  // Output stage: rows 0 and 1 only fill the memories; the taps hold their
  // last value whenever nothing is emitted.
  // --------------------------------------------------------------------------
  always_comb begin
    fire        = s2_q.vld && s2_q.tap;
    valid_out_d = fire;
    eol_out_d   = fire && s2_q.eol;
    eof_out_d   = fire && s2_q.eof;
    dout1_d     = fire ? ram_b_rdata : dout1_q;
    dout2_d     = fire ? ram_a_rdata : dout2_q;
    dout3_d     = fire ? din_d2_q    : dout3_q;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      din_d1_q    <= '0;
      din_d2_q    <= '0;
      valid_out_q <= 1'b0;
      eol_out_q   <= 1'b0;
      eof_out_q   <= 1'b0;
      dout1_q     <= '0;
      dout2_q     <= '0;
      dout3_q     <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      din_d1_q    <= din_d1_d;
      din_d2_q    <= din_d2_d;
      valid_out_q <= valid_out_d;
      eol_out_q   <= eol_out_d;
      eof_out_q   <= eof_out_d;
      dout1_q     <= dout1_d;
      dout2_q     <= dout2_d;
      dout3_q     <= dout3_d;
    end
  end

  assign bus.valid_out = valid_out_q;
  assign bus.eol_out   = eol_out_q;
  assign bus.eof_out   = eof_out_q;
  assign bus.dout1     = dout1_q;
  assign bus.dout2     = dout2_q;
  assign bus.dout3     = dout3_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// ----------------------------------------------------------------------------
// tb_line_buffer_3row
// Two instances: a 4x4 geometry for the directed cases and the default
// 320x240 geometry for one random frame. Each driven pixel updates a
// two-row software model; pixels in row >= 2 push their expected taps and
// output cycle onto a scoreboard queue, popped as valid_out appears.
// ----------------------------------------------------------------------------
module tb_line_buffer_3row;
  import img_pkg::*;

  localparam int W  = 24;
  localparam int SW = 4;
  localparam int SH = 4;
  localparam int LW = 320;
  localparam int LH = 240;

  typedef struct {
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] d3;
    logic         eol;
    logic         eof;
    int unsigned  due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  line_buffer_3row_if #(.WIDTH(W)) bus_s ();
  line_buffer_3row_if #(.WIDTH(W)) bus_l ();

  line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(SW), .PIC_HEIGHT(SH)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(LW), .PIC_HEIGHT(LH)) u_dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model and scoreboards (index 0 = 4x4, 1 = 320x240)
  // --------------------------------------------------------------------------
  exp_t         sb_s[$];
  exp_t         sb_l[$];
  int           mr[2];
  int           mc[2];
  logic [W-1:0] m1[2][512];  // row y-1
  logic [W-1:0] m2[2][512];  // row y-2

  // Called just after a falling edge: drives the bus for the next rising
  // edge, updates the model, then waits for the following falling edge.
  task automatic drive(input int sel, input bit sof, input bit vld, input logic [W-1:0] pix);
    int   r, c, wid, hgt;
    exp_t e;
    wid = (sel == 0) ? SW : LW;
    hgt = (sel == 0) ? SH : LH;
    if (sel == 0) begin
      bus_s.sof = sof; bus_s.valid_in = vld; bus_s.din = pix;
    end else begin
      bus_l.sof = sof; bus_l.valid_in = vld; bus_l.din = pix;
    end
    if (sof) begin
      mr[sel] = 0;
      mc[sel] = 0;
    end
    if (vld) begin
      r = mr[sel];
      c = mc[sel];
      if (r >= 2) begin
        e.d1  = m2[sel][c];
        e.d2  = m1[sel][c];
        e.d3  = pix;
        e.eol = (c == wid - 1);
        e.eof = (c == wid - 1) && (r == hgt - 1);
        e.due = cyc + 3;
        if (sel == 0) sb_s.push_back(e);
        else          sb_l.push_back(e);
      end
      m2[sel][c] = m1[sel][c];
      m1[sel][c] = pix;
      if (c == wid - 1) begin
        mc[sel] = 0;
        mr[sel] = (r == hgt - 1) ? 0 : r + 1;
      end else begin
        mc[sel] = c + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 1'b0, 1'b0, '0);
    end
  endtask

  // Rows r_lo..r_hi of a 4x4 frame, pixel = base + row*16 + col; sof on (0,0).
  task automatic frame_rows(input int base, input bit gaps, input int r_lo, input int r_hi);
    for (int r = r_lo; r <= r_hi; r++) begin
      for (int c = 0; c < SW; c++) begin
        drive(0, (r == 0) && (c == 0), 1'b1, W'(base + r * 16 + c));
        if (gaps) drive(0, 1'b0, 1'b0, '0);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Output monitors (sample on the falling edge)
  // --------------------------------------------------------------------------
  int           n_out_s, n_eol_s, n_eof_s;
  int           n_out_l, n_eol_l, n_eof_l;
  bit           first_pend = 1'b0;
  logic [W-1:0] first_d1, first_d2, first_d3;
  exp_t         es, el;

  always @(negedge clk) begin
    if (bus_s.valid_out === 1'b1) begin
      n_out_s++;
      if (bus_s.eol_out) n_eol_s++;
      if (bus_s.eof_out) n_eof_s++;
      if (first_pend) begin
        first_d1   = bus_s.dout1;
        first_d2   = bus_s.dout2;
        first_d3   = bus_s.dout3;
        first_pend = 1'b0;
      end
      if (sb_s.size() == 0) begin
        check("s_unexpected_out", 32'd1, 32'd0);
      end else begin
        es = sb_s.pop_front();
        check("s_dout1",   32'(bus_s.dout1),   32'(es.d1));
        check("s_dout2",   32'(bus_s.dout2),   32'(es.d2));
        check("s_dout3",   32'(bus_s.dout3),   32'(es.d3));
        check("s_eol",     32'(bus_s.eol_out), 32'(es.eol));
        check("s_eof",     32'(bus_s.eof_out), 32'(es.eof));
        check("s_latency", cyc,                es.due);
      end
    end
  end

  always @(negedge clk) begin
    if (bus_l.valid_out === 1'b1) begin
      n_out_l++;
      if (bus_l.eol_out) n_eol_l++;
      if (bus_l.eof_out) n_eof_l++;
      if (sb_l.size() == 0) begin
        check("l_unexpected_out", 32'd1, 32'd0);
      end else begin
        el = sb_l.pop_front();
        check("l_dout1",   32'(bus_l.dout1),   32'(el.d1));
        check("l_dout2",   32'(bus_l.dout2),   32'(el.d2));
        check("l_dout3",   32'(bus_l.dout3),   32'(el.d3));
        check("l_eol",     32'(bus_l.eol_out), 32'(el.eol));
        check("l_eof",     32'(bus_l.eof_out), 32'(el.eof));
        check("l_latency", cyc,                el.due);
      end
    end
  end

  task automatic clear_counts();
    n_out_s = 0; n_eol_s = 0; n_eof_s = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus_s.valid_out), 32'd0);
    check({tag, "_dout1"}, 32'(bus_s.dout1),     32'd0);
    check({tag, "_dout2"}, 32'(bus_s.dout2),     32'd0);
    check({tag, "_dout3"}, 32'(bus_s.dout3),     32'd0);
    check({tag, "_eol"},   32'(bus_s.eol_out),   32'd0);
    check({tag, "_eof"},   32'(bus_s.eof_out),   32'd0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    bus_s.sof = 1'b0; bus_s.valid_in = 1'b0; bus_s.din = '0;
    bus_l.sof = 1'b0; bus_l.valid_in = 1'b0; bus_l.din = '0;
    mr = '{0, 0};
    mc = '{0, 0};
    clear_counts();
    n_out_l = 0; n_eol_l = 0; n_eof_l = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-stream with row-2 pixels in flight.
    frame_rows(0, 1'b0, 0, 1);
    drive(0, 1'b0, 1'b1, W'(32'h20));
    drive(0, 1'b0, 1'b1, W'(32'h21));
    rst_n = 1'b0;
    bus_s.valid_in = 1'b0;
    bus_s.sof      = 1'b0;
    sb_s.delete();
    mr[0] = 0;
    mc[0] = 0;
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("rst_hold");
    end
    rst_n = 1'b1;
    idle(4);
    check("rst_inflight_out", 32'(n_out_s), 32'd0);

    // 4x4 frame, continuous valid.
    clear_counts();
    first_pend = 1'b1;
    frame_rows(0, 1'b0, 0, 3);
    idle(4);
    check("cont_n_out",  32'(n_out_s), 32'd8);
    check("cont_n_eol",  32'(n_eol_s), 32'd2);
    check("cont_n_eof",  32'(n_eof_s), 32'd1);
    check("cont_first1", 32'(first_d1), 32'h00);
    check("cont_first2", 32'(first_d2), 32'h10);
    check("cont_first3", 32'(first_d3), 32'h20);

    // Same frame with valid_in toggling.
    clear_counts();
    first_pend = 1'b1;
    frame_rows(0, 1'b1, 0, 3);
    idle(4);
    check("gap_n_out",  32'(n_out_s), 32'd8);
    check("gap_n_eof",  32'(n_eof_s), 32'd1);
    check("gap_first3", 32'(first_d3), 32'h20);

    // Two back-to-back frames; frame 2 must not see frame 1 rows.
    clear_counts();
    frame_rows(32'h000, 1'b0, 0, 3);
    frame_rows(32'h100, 1'b0, 0, 1);
    check("b2b_f2_rows01_out", 32'(n_out_s), 32'd8);
    first_pend = 1'b1;
    frame_rows(32'h100, 1'b0, 2, 3);
    idle(4);
    check("b2b_n_out",  32'(n_out_s), 32'd16);
    check("b2b_n_eof",  32'(n_eof_s), 32'd2);
    check("b2b_first1", 32'(first_d1), 32'h100);
    check("b2b_first2", 32'(first_d2), 32'h110);
    check("b2b_first3", 32'(first_d3), 32'h120);

    // sof arriving with pixel (2,1): that pixel restarts the frame at (0,0).
    clear_counts();
    frame_rows(32'h000, 1'b0, 0, 1);
    drive(0, 1'b0, 1'b1, W'(32'h020));
    frame_rows(32'h200, 1'b0, 0, 1);
    check("sof_mid_rows01_out", 32'(n_out_s), 32'd1);
    frame_rows(32'h200, 1'b0, 2, 3);
    idle(4);
    check("sof_mid_n_out", 32'(n_out_s), 32'd9);
    check("sof_mid_n_eof", 32'(n_eof_s), 32'd1);
    check("s_sb_empty",    32'(sb_s.size()), 32'd0);

    // Default geometry, one random frame.
    for (int r = 0; r < LH; r++) begin
      for (int c = 0; c < LW; c++) begin
        drive(1, (r == 0) && (c == 0), 1'b1, W'($urandom));
      end
    end
    bus_l.valid_in = 1'b0;
    bus_l.sof      = 1'b0;
    repeat (4) @(negedge clk);
    check("l_n_out",    32'(n_out_l), 32'(238 * 320));
    check("l_n_eol",    32'(n_eol_l), 32'd238);
    check("l_n_eof",    32'(n_eof_l), 32'd1);
    check("l_sb_empty", 32'(sb_l.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
